// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential arithmetic responder:
//   opcode width and encodings, controller state encoding, and a small
//   opcode classification helper.
//   No ports (package).
package alu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_MUL = 3'd2;
  localparam logic [OPW-1:0] OP_DIV = 3'd3;
  localparam logic [OPW-1:0] OP_REM = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // DIV and REM share the divider datapath and differ only in which output
  // is taken at the end.
  function automatic logic is_div_op(input logic [OPW-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/seq_shift_div.sv
// seq_shift_div
//   W-cycle restoring divider, MSB of the dividend first. The first step is
//   taken on the start edge straight from the a/b inputs, the remaining
//   W-1 steps on the following edges.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     start         load a/b and take the first step
//     a, b          dividend, divisor (unsigned, sampled on start)
//     busy          steps still outstanding
//     done          quot/rem hold the final values (held until next start)
//     quot, rem     quotient and remainder
//   A zero divisor needs no special casing: every trial subtract succeeds,
//   giving an all-ones quotient and the dividend as remainder.
module seq_shift_div
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  divisor;
  logic [CW-1:0] cnt;
  logic [W:0]    first_step;
  logic [W:0]    next_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. Returns {fits, rem}.
  function automatic logic [W:0] div_step(input logic [W-1:0] r,
                                          input logic         qbit,
                                          input logic [W-1:0] d);
    logic [W:0] trial;
    logic [W:0] diff;
    trial = {r, qbit};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d}) begin
      return {1'b1, diff[W-1:0]};
    end
    return {1'b0, trial[W-1:0]};
  endfunction

  // Step on the live inputs for the start edge, and on the registered
  // operands for every later edge.
  always_comb begin
    first_step = div_step('0, a[W-1], b);
    next_step  = div_step(rem, quot[W-1], divisor);
  end

  // The quotient register doubles as the dividend shift register: each
  // step shifts a dividend bit out of the top and a quotient bit in at
  // the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      quot    <= {a[W-2:0], first_step[W]};
      rem     <= first_step[W-1:0];
      divisor <= b;
      cnt     <= CW'(W - 1);
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (busy) begin
      quot <= {quot[W-2:0], next_step[W]};
      rem  <= next_step[W-1:0];
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu_resp.sv
// seq_alu_resp
//   Multi-cycle arithmetic responder. Accepts one request (op, a, b) on a
//   valid/ready channel and returns one result on a valid/ready channel;
//   only one transaction is ever in flight.
//   ADD/SUB/illegal answer one cycle after accept; MUL/DIV/REM take W+1.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   request handshake (in_ready high only in IDLE)
//     in_op, in_a, in_b   opcode and unsigned operands
//     out_valid/out_ready response handshake
//     out_result          RW = 2*W bit result
//     out_err             only when ALU_ERR_FLAG_EN is defined: flags
//                         divide-by-zero and illegal opcodes
//   Build option: `define ALU_ERR_FLAG_EN to add the out_err port.
module seq_alu_resp
  import alu_pkg::*;
#(
  parameter  int W  = 8,
  localparam int RW = 2 * W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RW-1:0]  out_result
`ifdef ALU_ERR_FLAG_EN
  ,
  output logic           out_err
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [OPW-1:0] op_r;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  acc;
  logic [RW-1:0]  mcand;
  logic [W-1:0]   mplier;
`ifdef ALU_ERR_FLAG_EN
  logic           b_zero;
`endif

  logic           accept;
  logic           div_start;
  logic           div_busy;
  logic           div_done;
  logic [W-1:0]   div_quot;
  logic [W-1:0]   div_rem;
  logic [W:0]     add_sum;
  logic [W:0]     sub_diff;

  // Ready depends only on state, so no input reaches an output
  // combinationally.
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && is_div_op(in_op);

  // Bit W of the difference is the borrow, which is exactly the sign of
  // the two's complement result and is replicated across the upper half.
  always_comb begin
    add_sum  = {1'b0, in_a} + {1'b0, in_b};
    sub_diff = {1'b0, in_a} - {1'b0, in_b};
  end

  seq_shift_div #(.W(W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (in_a),
    .b     (in_b),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  // Controller plus inline shift-add multiplier. The first multiply step
  // (and the divider's first step) happens on the accept edge, so the
  // remaining W-1 steps finish as the counter walks down to zero and the
  // result is written on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_r       <= OP_ADD;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef ALU_ERR_FLAG_EN
      out_err    <= 1'b0;
      b_zero     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= in_op;
`ifdef ALU_ERR_FLAG_EN
            b_zero  <= (in_b == '0);
            out_err <= 1'b0;
`endif
            case (in_op)
              OP_ADD: begin
                out_result <= RW'(add_sum);
                out_valid  <= 1'b1;
                state      <= DONE;
              end
              OP_SUB: begin
                out_result <= {{(RW-W-1){sub_diff[W]}}, sub_diff};
                out_valid  <= 1'b1;
                state      <= DONE;
              end
              OP_MUL, OP_DIV, OP_REM: begin
                acc    <= in_b[0] ? RW'(in_a) : '0;
                mcand  <= RW'(in_a) << 1;
                mplier <= in_b >> 1;
                cnt    <= CW'(W - 1);
                state  <= CALC;
              end
              default: begin
                out_result <= '0;
                out_valid  <= 1'b1;
`ifdef ALU_ERR_FLAG_EN
                out_err    <= 1'b1;
`endif
                state      <= DONE;
              end
            endcase
          end
        end

        CALC: begin
          if (cnt != '0) begin
            if (op_r == OP_MUL) begin
              if (mplier[0]) begin
                acc <= acc + mcand;
              end
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            cnt <= cnt - CW'(1);
          end else if ((op_r == OP_MUL) || (div_done && !div_busy)) begin
            if (op_r == OP_MUL) begin
              out_result <= acc;
            end else if (op_r == OP_DIV) begin
              out_result <= {{W{1'b0}}, div_quot};
            end else begin
              out_result <= {{W{1'b0}}, div_rem};
            end
`ifdef ALU_ERR_FLAG_EN
            out_err <= (op_r != OP_MUL) && b_zero;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_alu_resp.md
Name: seq_alu_resp

Overview:
- Multi-cycle arithmetic responder: accepts one operand pair plus opcode over a valid/ready request channel and returns one result over a valid/ready response channel.
- Sequential counterpart to the combinational add/minus/time/div/rest blocks. Serves as the shared arithmetic engine that stimulus generators and controllers drive as initiators.
- Add/sub complete in one cycle. Mul/div/rem use W-cycle shift algorithms to save area.

Parameters:
- W, 8, operand width in bits.
- RW, 2*W, result width; fixed by rule at 2*W, not user-overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5-7 illegal.
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  RW  result.
- out_err  out  1  present only with ALU_ERR_FLAG_EN.

Behaviour:
- Clock and reset: one clock domain (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state IDLE, out_valid=0, out_result=0, out_err=0, internal counter=0. in_ready = (state==IDLE), so it reads 1 during and after reset.
- States:
  - IDLE: in_ready=1. Accept on in_valid && in_ready; latch in_a, in_b, in_op. ADD, SUB and illegal opcodes go to DONE. MUL, DIV and REM go to CALC with the counter loaded to W-1.
  - CALC: one shift/add or shift/subtract step per cycle; the counter decrements. When the counter reaches 0, write out_result and go to DONE.
  - DONE: out_valid=1, out_result stable. On out_valid && out_ready go to IDLE.
- No overlap: in_ready=0 in CALC and DONE, so at most one transaction is in flight.
- Latency (accept edge to out_valid):
  - ADD/SUB/illegal: 1 cycle.
  - MUL/DIV/REM: W+1 cycles.
- Back-to-back: the earliest next accept is the cycle after the response handshake.
- Result rules (all results zero-extended to RW unless noted):
  - ADD: {0, a+b} W+1 bits, zero-extended; no overflow is possible.
  - SUB: a-b as RW-bit two's complement (sign-extended). Example: 75-90 gives 16'hFFF1.
  - MUL: full unsigned 2W-bit product via shift-add, LSB of B first.
  - DIV: quotient via restoring division, MSB of A first.
  - REM: remainder from the same datapath as DIV.
  - Illegal opcode: result 0.
- Divide by zero (DIV or REM with b=0): quotient = all ones (W bits), remainder = a. Latency is unchanged.
- out_ready held low in DONE: result and out_valid are held indefinitely; in_ready stays 0.
- in_valid ignored outside IDLE; operands are sampled only at the accept edge.
- rst asserted mid-CALC or mid-DONE: immediate return to IDLE, the result is discarded, and out_valid drops asynchronously.
- No combinational path from any input to any output except via state.

Optional Feature:
- Macro: ALU_ERR_FLAG_EN.
- Defined:
  - Adds the out_err port, registered and valid with out_valid.
  - out_err=1 for DIV/REM with b=0 and for illegal opcodes; otherwise 0.
  - Reset value 0.
- Not defined:
  - No out_err port.
  - Divide-by-zero and illegal-opcode results are as specified above, with no indication.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD..OP_REM.
  - Opcode width 3.
  - State encoding IDLE/CALC/DONE.
- One natural sub-module: seq_shift_div. It holds the W-cycle restoring divider (start, a, b, busy, done, quot, rem) and is instantiated once. MUL shift-add stays inline in seq_alu_resp.

Test Plan:
- ADD 90+102, out_ready=1 -> out_valid 1 cycle after accept, out_result=192.
- SUB 90-75 -> 15. SUB 75-90 -> 16'hFFF1.
- MUL 2*75 -> 150 after exactly W+1=9 cycles. MUL 200*255 -> 51000, checking full width with no truncation.
- DIV 102/2 -> 51. REM 102%75 -> 27. DIV 102/0 -> 255 and REM 102%0 -> 102; with ALU_ERR_FLAG_EN, out_err=1.
- Back-pressure on MUL 90*102:
  - Hold out_ready=0 for 5 cycles -> result 9180 stable, in_ready=0, new in_valid ignored.
  - Release -> handshake, in_ready=1 next cycle.
- Reset and illegal opcode:
  - Assert rst 3 cycles into DIV -> out_valid=0 immediately. After release, ADD 1+1 -> 2 with normal latency.
  - Opcode 6 -> result 0.
